// File: rtl/pipelined_mult_hs_if.sv
// Operand/product handshake bundle for pipelined_mult_hs.
// slave is the multiplier's view, master is the producer/consumer side.
interface pipelined_mult_hs_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/pipelined_mult_hs.sv
// Three-stage valid/ready multiplier: operand magnitudes, half-width partial
// products, then sum and sign fix-up. The whole pipe stalls when the output is held.
module pipelined_mult_hs #(
  parameter int W = 16
) (
  input logic                clk,
  input logic                rst,
  pipelined_mult_hs_if.slave bus
);
  localparam int H = W / 2;

  logic           adv;
  logic           s1_valid, s2_valid, s3_valid;
  logic [W-1:0]   s1_a, s1_b;
  logic           s1_neg;
  logic [W-1:0]   s2_ll, s2_lh, s2_hl, s2_hh;
  logic           s2_neg;
  logic [2*W-1:0] s3_p;

  logic [W-1:0]   mag_a, mag_b;
  logic           neg_in;
  logic [2*W-1:0] sum, prod;

  assign adv          = !s3_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = s3_valid;
  assign bus.out_p    = s3_p;
  assign bus.busy     = s1_valid || s2_valid || s3_valid;

  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
  always_comb begin
    mag_a  = (bus.in_signed && bus.in_a[W-1]) ? -bus.in_a : bus.in_a;
    mag_b  = (bus.in_signed && bus.in_b[W-1]) ? -bus.in_b : bus.in_b;
    neg_in = bus.in_signed && (bus.in_a[W-1] ^ bus.in_b[W-1]);
  end

  always_comb begin
    sum  = (2*W)'(s2_ll)
         + ((2*W)'(s2_lh) << H)
         + ((2*W)'(s2_hl) << H)
         + ((2*W)'(s2_hh) << W);
    prod = s2_neg ? -sum : sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_neg   <= 1'b0;
      s2_ll    <= '0;
      s2_lh    <= '0;
      s2_hl    <= '0;
      s2_hh    <= '0;
      s2_neg   <= 1'b0;
      s3_p     <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (bus.in_valid) begin
        s1_a   <= mag_a;
        s1_b   <= mag_b;
        s1_neg <= neg_in;
      end
      if (s1_valid) begin
        s2_ll  <= W'(s1_a[H-1:0]) * W'(s1_b[H-1:0]);
        s2_lh  <= W'(s1_a[H-1:0]) * W'(s1_b[W-1:H]);
        s2_hl  <= W'(s1_a[W-1:H]) * W'(s1_b[H-1:0]);
        s2_hh  <= W'(s1_a[W-1:H]) * W'(s1_b[W-1:H]);
        s2_neg <= s1_neg;
      end
      if (s2_valid) begin
        s3_p <= prod;
      end
    end
  end
endmodule

// File: doc/pipelined_mult_hs.md
PIPELINED_MULT_HS -- requirements
Module: pipelined_mult_hs

Interface
REQ-001 Parameter W, default 16, operand width; SHALL be even and >= 4; product width 2W.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand set on in_a/in_b/in_signed is offered.
REQ-005 in_ready  output  1  block accepts the offered operand set this cycle.
REQ-006 in_a  input  W  multiplicand.
REQ-007 in_b  input  W  multiplier.
REQ-008 in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled per transaction.
REQ-009 out_valid  output  1  out_p holds a valid product.
REQ-010 out_ready  input  1  downstream consumes out_p this cycle.
REQ-011 out_p  output  2W  product.
REQ-012 busy  output  1  at least one pipeline stage holds a valid transaction.

Function
REQ-013 Pipeline SHALL have exactly 3 register stages: S1 operand latch, S2 partial products, S3 final sum (out_p/out_valid).
REQ-014 Each stage SHALL carry a valid bit; data registers load only when the stage advances.
REQ-015 Advance enable adv = !out_valid | out_ready; all stages shift together when adv = 1, all hold when adv = 0.
REQ-016 in_ready SHALL equal adv (combinational); accept occurs when in_valid & in_ready.
REQ-017 On adv: S1.valid <= in_valid; S2.valid <= S1.valid; S3.valid <= S2.valid; a bubble (in_valid = 0) propagates as valid = 0.
REQ-018 S1 SHALL register in_a, in_b, in_signed; in signed mode it stores operand magnitudes (|x|, with -2^(W-1) giving 2^(W-1) as W-bit unsigned) plus result sign = sign(a) XOR sign(b).
REQ-019 S2 SHALL register four W-bit partial products of W/2-bit halves: lo*lo, lo*hi, hi*lo, hi*hi, plus the sign bit.
REQ-020 S3 SHALL form lo*lo + (lo*hi << W/2) + (hi*lo << W/2) + (hi*hi << W) in 2W bits, then two's-complement negate if the sign bit is 1.
REQ-021 out_p SHALL equal the exact mathematical product a*b in 2W bits (unsigned or signed per in_signed); no truncation or overflow is possible.
REQ-022 Latency: product of a transaction accepted in cycle N appears with out_valid = 1 in cycle N+3 when no stall occurs.
REQ-023 Throughput: one transaction per cycle while out_ready = 1.
REQ-024 While out_valid = 1 and out_ready = 0, out_p and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-025 Order SHALL be preserved; no transaction is dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 busy = S1.valid | S2.valid | S3.valid.
REQ-027 Zero operand in either mode SHALL yield out_p = 0 (no negative zero artefact).

Reset
REQ-028 While rst = 1: all valid bits 0, all data registers 0, out_p = 0, out_valid = 0, busy = 0.
REQ-029 in_ready SHALL be 1 while rst = 1 and immediately after release (combinational from out_valid = 0); accepts during rst = 1 are discarded.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight transactions; no product of a pre-reset transaction appears after release.

Verification
REQ-031 W=16, out_ready=1, in_signed=0, a=0xFFFF, b=0xFFFF accepted cycle N -> out_valid=1, out_p=0xFFFE0001 in cycle N+3 only.
REQ-032 W=16 signed: (0xFFFF,0xFFFF) -> 0x00000001; (0x8000,0x8000) -> 0x40000000; (0x8000,0x7FFF) -> 0xC0008000; (0x0000,0x8000) -> 0x00000000.
REQ-033 Back-to-back stream of 8 random transactions with alternating in_signed, out_ready=1 -> 8 correct products on 8 consecutive cycles starting 3 cycles after first accept.
REQ-034 Stall: fill pipeline with 3 transactions, hold out_ready=0 for 5 cycles -> in_ready=0, out_p stable on first product; release -> remaining products in order, none lost.
REQ-035 Random in_valid and out_ready (50 %) for 1000 transactions, W=8 and W=32 -> scoreboard match, order preserved.
REQ-036 Assert rst with 2 transactions in flight -> out_valid=0, out_p=0, busy=0 immediately; after release no stale product emitted, next accept yields correct product at N+3.
